leitor_7seg: RTL and testbench

Reader side of the 7-segment display path: samples a multiplexed display bus and recovers BCD digits. It watches the active-high segment lines `seg` and the one-hot digit strobes `dig_sel`, and accepts a digit only after its pattern has been stable for a set number of cycles. Once every digit has been captured, it presents the whole frame on a valid/ready output port. It sits next to the display driver and serves self-check and loopback capture.

---
 rtl/leitor_7seg_pkg.sv | 26 ++
 rtl/seg7_para_bcd.sv | 30 +++
 rtl/leitor_7seg.sv | 127 ++++++++++++
 tb/tb_leitor_7seg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leitor_7seg_pkg.sv
// Shared constants and types for the 7-segment reader: segment patterns,
// special BCD codes and the frame FSM state encoding.
package leitor_7seg_pkg;

    // seg[6:0] = {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h1F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_INVALID = 4'hE;
    localparam logic [3:0] BCD_BLANK   = 4'hF;

    typedef enum logic {
        COLETA = 1'b0,
        PRONTO = 1'b1
    } estado_t;

endpackage

// File: rtl/seg7_para_bcd.sv
// Combinational lookup from a 7-segment pattern to a BCD digit plus an
// error flag for patterns that are neither a digit nor blank.
module seg7_para_bcd
    import leitor_7seg_pkg::*;
(
    input  logic [6:0] padrao,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b1;
        case (padrao)
            SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
            SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
            SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
            SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
            SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
            SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
            SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
            SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
            SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
            SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
            SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/leitor_7seg.sv
// Samples a multiplexed 7-segment bus, debounces each digit and emits whole
// frames on a valid/ready port. Define LEITOR_7SEG_DP_EN to capture the DP.
module leitor_7seg
    import leitor_7seg_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            seg,
    input  logic [N_DIGITS-1:0]   dig_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_DIGITS-1:0] out_bcd,
    output logic [N_DIGITS-1:0]   out_err,
    output logic [N_DIGITS-1:0]   out_dp,
    output estado_t               estado
);

    // Handshake: a frame moves to the consumer on any rising edge where
    // out_valid && out_ready; out_bcd/out_err/out_dp hold while out_valid && !out_ready.

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]       CNT_MAX = CW'(STABLE_CNT);
    localparam logic [N_DIGITS-1:0] SEL_UM  = N_DIGITS'(1);
`ifdef LEITOR_7SEG_DP_EN
    localparam logic DP_ON = 1'b1;
`else
    localparam logic DP_ON = 1'b0;
`endif
    // With DP disabled bit 7 is masked out of the compare and the capture
    localparam logic [7:0] CMP_MASK = {DP_ON, 7'h7F};

    logic [7:0]            seg_r, seg_p;
    logic [N_DIGITS-1:0]   sel_r, sel_p;
    logic [CW-1:0]         cnt, cnt_next;
    logic [N_DIGITS-1:0]   mask;
    logic [4*N_DIGITS-1:0] work_bcd;
    logic [N_DIGITS-1:0]   work_err, work_dp;
    estado_t               state, state_next;

    logic                  one_hot, differ, captura, transfer;
    logic [3:0]            dec_bcd;
    logic                  dec_err;

    seg7_para_bcd u_dec (
        .padrao (seg_r[6:0]),
        .bcd    (dec_bcd),
        .err    (dec_err)
    );

    assign estado = state;

    always_comb begin
        one_hot  = (sel_r != '0) && ((sel_r & (sel_r - SEL_UM)) == '0);
        differ   = (sel_r != sel_p) || (((seg_r ^ seg_p) & CMP_MASK) != 8'h00);
        cnt_next = cnt;
        if (!one_hot)
            cnt_next = '0;
        else if (differ)
            cnt_next = CW'(1);
        else if (cnt != CNT_MAX)
            cnt_next = cnt + CW'(1);
        captura  = one_hot && (cnt_next == CNT_MAX) && (state == COLETA)
                   && ((sel_r & mask) == '0);
        transfer = (state == PRONTO) && (!out_valid || out_ready);
    end

    always_comb begin
        state_next = state;
        case (state)
            COLETA:  if (&mask) state_next = PRONTO;
            PRONTO:  if (transfer) state_next = COLETA;
            default: state_next = COLETA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r     <= '0;
            seg_p     <= '0;
            sel_r     <= '0;
            sel_p     <= '0;
            cnt       <= '0;
            mask      <= '0;
            work_bcd  <= '0;
            work_err  <= '0;
            work_dp   <= '0;
            state     <= COLETA;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_err   <= '0;
            out_dp    <= '0;
        end else begin
            seg_r <= seg;
            seg_p <= seg_r;
            sel_r <= dig_sel;
            sel_p <= sel_r;
            cnt   <= cnt_next;
            state <= state_next;

            if (transfer) begin
                out_bcd   <= work_bcd;
                out_err   <= work_err;
                out_dp    <= work_dp;
                out_valid <= 1'b1;
                mask      <= '0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // captura is only possible in COLETA, transfer only in PRONTO
            if (captura) begin
                mask <= mask | sel_r;
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (sel_r[k]) begin
                        work_bcd[4*k +: 4] <= dec_bcd;
                        work_err[k]        <= dec_err;
                        work_dp[k]         <= seg_r[7] & DP_ON;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_leitor_7seg.sv
// Directed bench for leitor_7seg: frame capture, dwell, decode, backpressure,
// strobe errors, reset and decimal point.
module tb_leitor_7seg;
    import leitor_7seg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  seg = 8'h00;
    logic [3:0]  dig_sel = 4'b0000;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
    logic [3:0]  out_dp;
    estado_t     estado;

    int checks = 0;
    int failures = 0;

    logic [15:0] got_bcd;
    logic [3:0]  got_err, got_dp;
    int          got_lat;
    bit          found;

    leitor_7seg #(.N_DIGITS(4), .STABLE_CNT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_dp    (out_dp),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] sel, input logic [7:0] s, input int n);
        dig_sel = sel;
        seg     = s;
        step(n);
    endtask

    task automatic idle();
        dig_sel = 4'b0000;
        seg     = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
        hold(4'b1000, s3, 5);
        hold(4'b0100, s2, 5);
        hold(4'b0010, s1, 5);
        hold(4'b0001, s0, 5);
        idle();
    endtask

    task automatic wait_frame(input int max);
        found   = 1'b0;
        got_lat = 0;
        while (!found && got_lat < max) begin
            @(negedge clk);
            got_lat++;
            if (out_valid === 1'b1) begin
                found   = 1'b1;
                got_bcd = out_bcd;
                got_err = out_err;
                got_dp  = out_dp;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", out_bcd); end
        checks++;
        if (out_err !== 4'b0000 || out_dp !== 4'b0000) begin
            failures++; $display("FAIL reset_err_dp got err=%b dp=%b exp=0000/0000", out_err, out_dp);
        end
        checks++;
        if (estado !== COLETA) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", estado, COLETA); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_frame_1234();
        out_ready = 1'b1;
        send_frame(8'h30, 8'h6D, 8'h79, 8'h33);
        wait_frame(20);
        checks++;
        if (!found) begin failures++; $display("FAIL f1234_timeout no out_valid in 20 cycles"); end
        checks++;
        if (got_bcd !== 16'h1234) begin failures++; $display("FAIL f1234_bcd got=%h exp=1234", got_bcd); end
        checks++;
        if (got_err !== 4'b0000) begin failures++; $display("FAIL f1234_err got=%b exp=0000", got_err); end
        checks++;
        if (got_lat !== 2) begin failures++; $display("FAIL f1234_latency got=%0d exp=2", got_lat); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL f1234_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_short_dwell();
        hold(4'b1000, 8'h7E, 5);
        hold(4'b0100, 8'h7F, 5);
        hold(4'b0010, 8'h5B, 5);
        hold(4'b0001, 8'h7E, 2);
        hold(4'b0001, 8'h30, 3);
        idle();
        wait_frame(20);
        checks++;
        if (!found) begin failures++; $display("FAIL dwell_timeout no out_valid in 20 cycles"); end
        checks++;
        if (got_bcd !== 16'h0851) begin failures++; $display("FAIL dwell_bcd got=%h exp=0851", got_bcd); end
        step(2);
    endtask

    task automatic test_invalid_blank();
        send_frame(8'h00, 8'h55, 8'h1F, 8'h70);
        wait_frame(20);
        checks++;
        if (!found) begin failures++; $display("FAIL inv_timeout no out_valid in 20 cycles"); end
        checks++;
        if (got_bcd !== 16'hFE67) begin failures++; $display("FAIL inv_bcd got=%h exp=FE67", got_bcd); end
        checks++;
        if (got_err !== 4'b0100) begin failures++; $display("FAIL inv_err got=%b exp=0100", got_err); end
        step(2);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(8'h30, 8'h6D, 8'h79, 8'h33);
        wait_frame(20);
        checks++;
        if (!found || got_bcd !== 16'h1234) begin
            failures++; $display("FAIL bp_first found=%b got=%h exp=1234", found, got_bcd);
        end
        send_frame(8'h5B, 8'h1F, 8'h70, 8'h7F);
        step(4);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h1234) begin
            failures++; $display("FAIL bp_hold valid=%b got=%h exp=1/1234", out_valid, out_bcd);
        end
        checks++;
        if (estado !== PRONTO) begin failures++; $display("FAIL bp_state got=%0d exp=%0d", estado, PRONTO); end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h5678) begin
            failures++; $display("FAIL bp_next valid=%b got=%h exp=1/5678", out_valid, out_bcd);
        end
        step(3);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h5678) begin
            failures++; $display("FAIL bp_stable valid=%b got=%h exp=1/5678", out_valid, out_bcd);
        end
        out_ready = 1'b1;
        step(2);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_non_onehot();
        out_ready = 1'b1;
        hold(4'b1000, 8'h7F, 5);
        hold(4'b0100, 8'h6D, 5);
        hold(4'b0011, 8'h7B, 10);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL noh_valid got=%b exp=0", out_valid); end
        hold(4'b0010, 8'h30, 5);
        hold(4'b0001, 8'h7E, 5);
        idle();
        wait_frame(20);
        checks++;
        if (!found || got_bcd !== 16'h8210) begin
            failures++; $display("FAIL noh_bcd found=%b got=%h exp=8210", found, got_bcd);
        end
        step(2);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_frame(8'h30, 8'h30, 8'h30, 8'h30);
        wait_frame(20);
        hold(4'b1000, 8'h79, 5);
        hold(4'b0100, 8'h33, 5);
        idle();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 16'h0000) begin
            failures++; $display("FAIL rstmid_out valid=%b got=%h exp=0/0000", out_valid, out_bcd);
        end
        out_ready = 1'b1;
        step(1);
        send_frame(8'h1F, 8'h70, 8'h7B, 8'h5B);
        wait_frame(20);
        checks++;
        if (!found || got_bcd !== 16'h6795) begin
            failures++; $display("FAIL rstmid_bcd found=%b got=%h exp=6795", found, got_bcd);
        end
        step(2);
    endtask

    task automatic test_dp();
        logic [3:0] exp_dp;
`ifdef LEITOR_7SEG_DP_EN
        exp_dp = 4'b0001;
`else
        exp_dp = 4'b0000;
`endif
        send_frame(8'h30, 8'h30, 8'h30, 8'hFE);
        wait_frame(20);
        checks++;
        if (!found || got_bcd !== 16'h1110) begin
            failures++; $display("FAIL dp_bcd found=%b got=%h exp=1110", found, got_bcd);
        end
        checks++;
        if (got_dp !== exp_dp) begin failures++; $display("FAIL dp_flag got=%b exp=%b", got_dp, exp_dp); end
        step(2);
    endtask

    initial begin
        test_reset();
        test_frame_1234();
        test_short_dwell();
        test_invalid_blank();
        test_backpressure();
        test_non_onehot();
        test_reset_mid();
        test_dp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
